// File: rtl/sr_divider_10b5b_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_divider_10b5b_pkg : widths, iteration count, FSM state codes  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sr_divider_10b5b_pkg;

  localparam int DVD_W  = 10;
  localparam int DVS_W  = 5;
  localparam int P_W    = 6;
  localparam int N_ITER = 10;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sr_divider_10b5b_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_divider_10b5b_fsm : state register, iteration counter and     |
// | datapath control strobes for the restoring divider. Rev 1.0      |
// +------------------------------------------------------------------+
module sr_divider_10b5b_fsm
  import sr_divider_10b5b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic dvs_zero,
  output logic ld,
  output logic shift,
  output logic latch_out,
  output logic latch_div0,
  output logic busy,
  output logic done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld         = 1'b0;
    shift      = 1'b0;
    latch_out  = 1'b0;
    latch_div0 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn) begin
          ld    = 1'b1;
          cnt_d = '0;
          // A zero divisor skips iteration entirely and reports at once.
          if (dvs_zero) begin
            latch_div0 = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        shift = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          latch_out = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/sr_divider_10b5b.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_divider_10b5b : 10-bit / 5-bit unsigned shift-subtract        |
// | divider, one quotient bit per cycle. Rev 1.0                     |
// +------------------------------------------------------------------+
module sr_divider_10b5b
  import sr_divider_10b5b_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  input  logic [DVD_W-1:0] DVD,
  input  logic [DVS_W-1:0] DVS,
  output logic [DVD_W-1:0] QUO,
  output logic [DVS_W-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0
);

  logic ld, shift, latch_out, latch_div0;

  sr_divider_10b5b_fsm u_fsm (
    .clk        (CLK),
    .rst        (RST),
    .btn        (BTN),
    .dvs_zero   (DVS == '0),
    .ld         (ld),
    .shift      (shift),
    .latch_out  (latch_out),
    .latch_div0 (latch_div0),
    .busy       (BUSY),
    .done       (DONE)
  );

  logic [P_W-1:0]   p_q, p_d;
  logic [DVD_W-1:0] q_q, q_d;
  logic [DVS_W-1:0] d_q, d_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;

  logic [P_W-1:0]   p_sh, p_it;
  logic [DVD_W-1:0] q_it;
  logic             ge;

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div0_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      q_q    <= q_d;
      d_q    <= d_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div0_q <= div0_d;
    end
  end

  // One restoring step: P holds < D, so the shifted P fits in 6 bits.
  always_comb begin
    p_sh = {p_q[P_W-2:0], q_q[DVD_W-1]};
    ge   = (p_sh >= {1'b0, d_q});
    p_it = ge ? (p_sh - {1'b0, d_q}) : p_sh;
    q_it = {q_q[DVD_W-2:0], ge};
  end

  always_comb begin
    p_d    = p_q;
    q_d    = q_q;
    d_d    = d_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div0_d = div0_q;
    if (ld) begin
      q_d = DVD;
      d_d = DVS;
      p_d = '0;
    end
    if (shift) begin
      p_d = p_it;
      q_d = q_it;
    end
    // Results move only on entry to DONE and are otherwise held.
    if (latch_out) begin
      quo_d  = q_it;
      rem_d  = p_it[DVS_W-1:0];
      div0_d = 1'b0;
    end
    if (latch_div0) begin
      quo_d  = '1;
      rem_d  = '0;
      div0_d = 1'b1;
    end
  end

  assign QUO  = quo_q;
  assign REM  = rem_q;
  assign DIV0 = div0_q;

endmodule
`default_nettype wire
